// File: rtl/ct_f_spsram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ct_f_spsram_ctrl_pkg
//  Description : Shared types and constants for the 512x54 single-port SRAM
//                access controller: FSM state encoding, idle pin levels and
//                the half-word width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ct_f_spsram_ctrl_pkg;

    // Controller FSM: zero-fill sweep or normal arbitrated access.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Pin levels driven when the macro port is not in use (macro pins are
    // active-low, so idle means every enable deasserted).
    localparam logic c_idle_cen     = 1'b1;
    localparam logic c_idle_gwen    = 1'b1;
    localparam logic c_idle_wen_bit = 1'b1;
    localparam logic c_idle_d_bit   = 1'b0;
    localparam logic c_idle_a_bit   = 1'b0;

    // Lower half-word width; the upper half takes the remaining bits.
    function automatic int half_width(input int dw);
        return dw / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ct_f_spsram_512x54_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ct_f_spsram_512x54_ctrl_if
//  Description : Bundle of requester-side and macro-side signals of the
//                single-port SRAM controller.
//  Revision    : 1.0 - initial release
//  Modports    : slave  - the controller (drives grants and macro pins)
//                master - the surrounding logic (requesters and macro Q)
// ============================================================================
interface ct_f_spsram_512x54_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 54
);
    logic                  init_req;
    logic                  init_busy;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [1:0]            wr_mask;
    logic                  wr_gnt;
    logic [ADDR_WIDTH-1:0] sram_A;
    logic                  sram_CEN;
    logic                  sram_GWEN;
    logic [DATA_WIDTH-1:0] sram_WEN;
    logic [DATA_WIDTH-1:0] sram_D;
    logic [DATA_WIDTH-1:0] sram_Q;

    modport slave (
        input  init_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask,
               sram_Q,
        output init_busy, rd_gnt, rd_vld, rd_data, wr_gnt,
               sram_A, sram_CEN, sram_GWEN, sram_WEN, sram_D
    );

    modport master (
        output init_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask,
               sram_Q,
        input  init_busy, rd_gnt, rd_vld, rd_data, wr_gnt,
               sram_A, sram_CEN, sram_GWEN, sram_WEN, sram_D
    );
endinterface
`default_nettype wire

// File: rtl/ct_f_spsram_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : ct_f_spsram_rr_arb2
//  Description : Two-requester (read/write) round-robin arbiter. Grants are
//                combinational; the priority bit flips only on cycles where
//                both requesters compete, so the loser wins next contention.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                i_en        - arbitration allowed this cycle
//                i_req_rd/wr - requests
//                o_gnt_rd/wr - one-hot (or zero) grants
// ============================================================================
module ct_f_spsram_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_rd,
    input  logic i_req_wr,
    output logic o_gnt_rd,
    output logic o_gnt_wr
);
    logic r_prio_wr;
    logic w_contend;

    assign w_contend = i_en & i_req_rd & i_req_wr;
    assign o_gnt_rd  = i_en & i_req_rd & (~i_req_wr | ~r_prio_wr);
    assign o_gnt_wr  = i_en & i_req_wr & (~i_req_rd |  r_prio_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_wr <= 1'b0;
        end else if (w_contend) begin
            r_prio_wr <= ~r_prio_wr;
        end
    end
endmodule
`default_nettype wire

// File: rtl/ct_f_spsram_512x54_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ct_f_spsram_512x54_ctrl
//  Description : Access controller for the 512x54 single-port SRAM macro.
//                Arbitrates one reader and one writer onto the port, runs a
//                zero-fill sweep after reset or on request, and returns read
//                data one cycle after the read grant.
//  Revision    : 1.0 - initial release
//  Ports       : CLK, RST - clock, synchronous active-high reset
//                bus      - slave view of ct_f_spsram_512x54_ctrl_if
//                           (requests/grants, read return, macro pins)
// ============================================================================
module ct_f_spsram_512x54_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 54,
    parameter int HALF_WIDTH    = half_width(DATA_WIDTH),
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    ct_f_spsram_512x54_ctrl_if.slave bus
);
    localparam state_e                c_reset_state = state_e'(INIT_ON_RESET ? ST_INIT : ST_RUN);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr   = '1;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic [ADDR_WIDTH-1:0] w_init_addr_nxt;
    logic                  r_rd_vld;

    logic                  w_arb_en;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;

    logic                  w_cen;
    logic                  w_gwen;
    logic [ADDR_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_wen;
    logic [DATA_WIDTH-1:0] w_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_reset_state;
            r_init_addr <= '0;
            r_rd_vld    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_addr <= w_init_addr_nxt;
            r_rd_vld    <= w_rd_gnt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_init_addr_nxt = r_init_addr;
        case (r_state)
            ST_INIT: begin
                // Counter wraps to zero naturally after the last entry.
                w_init_addr_nxt = r_init_addr + ADDR_WIDTH'(1);
                if (r_init_addr == c_last_addr) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.init_req) begin
                    w_state_nxt     = ST_INIT;
                    w_init_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = c_reset_state;
                w_init_addr_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration (only in RUN; reset forces all grants low)
    // ------------------------------------------------------------------
    assign w_arb_en = (r_state == ST_RUN) & ~RST;

    ct_f_spsram_rr_arb2 u_arb (
        .clk      (CLK),
        .rst      (RST),
        .i_en     (w_arb_en),
        .i_req_rd (bus.rd_req),
        .i_req_wr (bus.wr_req),
        .o_gnt_rd (w_rd_gnt),
        .o_gnt_wr (w_wr_gnt)
    );

    // ------------------------------------------------------------------
    // Output logic: macro pin drive
    // ------------------------------------------------------------------
    always_comb begin
        w_cen  = c_idle_cen;
        w_gwen = c_idle_gwen;
        w_a    = {ADDR_WIDTH{c_idle_a_bit}};
        w_wen  = {DATA_WIDTH{c_idle_wen_bit}};
        w_d    = {DATA_WIDTH{c_idle_d_bit}};
        if (!RST) begin
            if (r_state == ST_INIT) begin
                w_cen  = 1'b0;
                w_gwen = 1'b0;
                w_wen  = '0;
                w_a    = r_init_addr;
            end else if (w_wr_gnt) begin
                w_cen  = 1'b0;
                // An all-zero mask still takes the port but writes nothing.
                w_gwen = ~|bus.wr_mask;
                w_a    = bus.wr_addr;
                w_d    = bus.wr_data;
                w_wen[HALF_WIDTH-1:0]          = {HALF_WIDTH{~bus.wr_mask[0]}};
                w_wen[DATA_WIDTH-1:HALF_WIDTH] = {(DATA_WIDTH-HALF_WIDTH){~bus.wr_mask[1]}};
            end else if (w_rd_gnt) begin
                w_cen = 1'b0;
                w_a   = bus.rd_addr;
            end
        end
    end

    assign bus.sram_CEN  = w_cen;
    assign bus.sram_GWEN = w_gwen;
    assign bus.sram_A    = w_a;
    assign bus.sram_WEN  = w_wen;
    assign bus.sram_D    = w_d;

    assign bus.rd_gnt    = w_rd_gnt;
    assign bus.wr_gnt    = w_wr_gnt;
    assign bus.rd_vld    = r_rd_vld & ~RST;
    assign bus.rd_data   = (r_rd_vld & ~RST) ? bus.sram_Q : '0;
    // During reset the state register may not yet hold its reset value, so
    // the busy flag is forced to the value it will take.
    assign bus.init_busy = RST ? INIT_ON_RESET : (r_state == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_512x54_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ct_f_spsram_512x54_ctrl
//  Description : Self-checking bench for ct_f_spsram_512x54_ctrl with a
//                behavioural model of the 512x54 macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_f_spsram_512x54_ctrl;

    localparam logic [53:0] C_ONES  = {54{1'b1}};
    localparam logic [53:0] C_Z     = 54'd0;
    localparam logic [53:0] C_A1    = 54'h2A_AAAA_AAAA_AAAA;
    localparam logic [53:0] C_LO27  = 54'h7FF_FFFF;
    localparam logic [53:0] C_WENLO = {27'h7FF_FFFF, 27'd0};
    localparam logic [53:0] C_D55   = 54'h55;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic preload = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    ct_f_spsram_512x54_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(54)) u_if ();

    ct_f_spsram_512x54_ctrl #(
        .ADDR_WIDTH    (9),
        .DATA_WIDTH    (54),
        .HALF_WIDTH    (27),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if)
    );

    always #5 CLK = ~CLK;

    // Macro model: active-low enables, per-bit write mask, Q updated on reads.
    logic [53:0] mem [512];
    logic [53:0] r_q;
    assign u_if.sram_Q = r_q;

    always @(posedge CLK) begin
        if (preload) begin
            for (int k = 0; k < 512; k++) mem[k] <= 54'h15_5555_5555_5555 ^ 54'(k);
            r_q <= C_Z;
        end else if (!u_if.sram_CEN) begin
            if (!u_if.sram_GWEN)
                mem[u_if.sram_A] <= (mem[u_if.sram_A] & u_if.sram_WEN) |
                                    (u_if.sram_D & ~u_if.sram_WEN);
            else
                r_q <= mem[u_if.sram_A];
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rd_req;
        logic [8:0]  rd_addr;
        logic        wr_req;
        logic [8:0]  wr_addr;
        logic [53:0] wr_data;
        logic [1:0]  wr_mask;
        logic        e_rg;
        logic        e_wg;
        logic        e_cen;
        logic        e_gwen;
        logic [8:0]  e_a;
        logic [53:0] e_wen;
        logic [53:0] e_d;
        logic        e_vld;
        logic [53:0] e_rdata;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt;

        vecs[0]  = '{1'b0, 9'd0, 1'b0, 9'd0, C_Z,        2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, C_ONES,  C_Z,        1'b0, C_Z};
        vecs[1]  = '{1'b0, 9'd0, 1'b1, 9'd5, C_A1,       2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 9'd5, C_Z,     C_A1,       1'b0, C_Z};
        vecs[2]  = '{1'b1, 9'd5, 1'b0, 9'd0, C_Z,        2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd5, C_ONES,  C_Z,        1'b0, C_Z};
        vecs[3]  = '{1'b0, 9'd0, 1'b0, 9'd0, C_Z,        2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, C_ONES,  C_Z,        1'b1, C_A1};
        vecs[4]  = '{1'b0, 9'd0, 1'b1, 9'd7, C_ONES,     2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 9'd7, C_WENLO, C_ONES,     1'b0, C_Z};
        vecs[5]  = '{1'b1, 9'd7, 1'b0, 9'd0, C_Z,        2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd7, C_ONES,  C_Z,        1'b0, C_Z};
        vecs[6]  = '{1'b0, 9'd0, 1'b0, 9'd0, C_Z,        2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, C_ONES,  C_Z,        1'b1, C_LO27};
        vecs[7]  = '{1'b0, 9'd0, 1'b1, 9'd9, 54'h123,    2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd9, C_ONES,  54'h123,    1'b0, C_Z};
        vecs[8]  = '{1'b1, 9'd5, 1'b1, 9'd3, C_D55,      2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 9'd5, C_ONES,  C_Z,        1'b0, C_Z};
        vecs[9]  = '{1'b1, 9'd5, 1'b1, 9'd3, C_D55,      2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 9'd3, C_Z,     C_D55,      1'b1, C_A1};
        vecs[10] = '{1'b1, 9'd5, 1'b1, 9'd3, C_D55,      2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 9'd5, C_ONES,  C_Z,        1'b0, C_Z};
        vecs[11] = '{1'b1, 9'd5, 1'b1, 9'd3, C_D55,      2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 9'd3, C_Z,     C_D55,      1'b1, C_A1};
        vecs[12] = '{1'b1, 9'd3, 1'b1, 9'd4, 54'h77,     2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 9'd3, C_ONES,  C_Z,        1'b0, C_Z};
        vecs[13] = '{1'b1, 9'd9, 1'b0, 9'd0, C_Z,        2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd9, C_ONES,  C_Z,        1'b1, C_D55};
        vecs[14] = '{1'b0, 9'd0, 1'b0, 9'd0, C_Z,        2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, C_ONES,  C_Z,        1'b1, C_Z};
        vecs[15] = '{1'b0, 9'd0, 1'b0, 9'd0, C_Z,        2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0, C_ONES,  C_Z,        1'b0, C_Z};

        u_if.init_req = 1'b0;
        u_if.rd_req   = 1'b1;
        u_if.rd_addr  = 9'h1FF;
        u_if.wr_req   = 1'b1;
        u_if.wr_addr  = 9'd3;
        u_if.wr_data  = C_ONES;
        u_if.wr_mask  = 2'd3;

        // ---------------- reset state (requests held, must be ignored)
        @(negedge CLK);
        preload = 1'b0;
        @(negedge CLK);
        #1;
        chk("reset_ctl", {u_if.rd_gnt, u_if.wr_gnt, u_if.rd_vld, u_if.init_busy},
                         {1'b0, 1'b0, 1'b0, 1'b1});
        chk("reset_pins", {u_if.sram_CEN, u_if.sram_GWEN, u_if.sram_A, u_if.sram_WEN, u_if.sram_D},
                          {1'b1, 1'b1, 9'd0, C_ONES, C_Z});

        // ---------------- sweep after reset release; read held throughout
        @(negedge CLK);
        RST = 1'b0;
        u_if.wr_req = 1'b0;
        for (int i = 0; i < 512; i++) begin
            if (i != 0) @(negedge CLK);
            #1;
            chk($sformatf("sweep1_c%0d", i),
                {u_if.init_busy, u_if.rd_gnt, u_if.wr_gnt, u_if.sram_CEN, u_if.sram_GWEN,
                 u_if.sram_WEN, u_if.sram_D, u_if.sram_A},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_Z, C_Z, 9'(i)});
            // init_req during the sweep must not restart it
            u_if.init_req = (i == 100);
        end
        @(negedge CLK);
        #1;
        chk("sweep1_end", {u_if.init_busy, u_if.rd_gnt, u_if.wr_gnt, u_if.sram_CEN,
                           u_if.sram_GWEN, u_if.sram_A},
                          {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF});
        @(negedge CLK);
        u_if.rd_req = 1'b0;
        #1;
        chk("rd_1ff", {u_if.rd_vld, u_if.rd_data}, {1'b1, C_Z});

        // ---------------- table-driven RUN vectors
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            u_if.rd_req  = vecs[i].rd_req;
            u_if.rd_addr = vecs[i].rd_addr;
            u_if.wr_req  = vecs[i].wr_req;
            u_if.wr_addr = vecs[i].wr_addr;
            u_if.wr_data = vecs[i].wr_data;
            u_if.wr_mask = vecs[i].wr_mask;
            #1;
            chk($sformatf("v%0d_gnt", i), {u_if.init_busy, u_if.rd_gnt, u_if.wr_gnt},
                                          {1'b0, vecs[i].e_rg, vecs[i].e_wg});
            chk($sformatf("v%0d_pins", i),
                {u_if.sram_CEN, u_if.sram_GWEN, u_if.sram_A, u_if.sram_WEN, u_if.sram_D},
                {vecs[i].e_cen, vecs[i].e_gwen, vecs[i].e_a, vecs[i].e_wen, vecs[i].e_d});
            chk($sformatf("v%0d_rdata", i), {u_if.rd_vld, u_if.rd_data},
                                            {vecs[i].e_vld, vecs[i].e_rdata});
        end

        // ---------------- init_req together with a write in RUN
        @(negedge CLK);
        u_if.init_req = 1'b1;
        u_if.wr_req   = 1'b1;
        u_if.wr_addr  = 9'd20;
        u_if.wr_data  = 54'h3F_0F0F_0F0F_0F0F;
        u_if.wr_mask  = 2'd3;
        #1;
        chk("initreq_wr", {u_if.init_busy, u_if.wr_gnt, u_if.sram_CEN, u_if.sram_GWEN, u_if.sram_A},
                          {1'b0, 1'b1, 1'b0, 1'b0, 9'd20});
        @(negedge CLK);
        u_if.init_req = 1'b0;
        for (int i = 0; i < 512; i++) begin
            if (i != 0) @(negedge CLK);
            #1;
            chk($sformatf("sweep2_c%0d", i),
                {u_if.init_busy, u_if.rd_gnt, u_if.wr_gnt, u_if.sram_CEN, u_if.sram_GWEN,
                 u_if.sram_WEN, u_if.sram_D, u_if.sram_A},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_Z, C_Z, 9'(i)});
        end
        @(negedge CLK);
        u_if.wr_req  = 1'b0;
        u_if.rd_req  = 1'b1;
        u_if.rd_addr = 9'd5;
        #1;
        chk("post2_gnt", {u_if.init_busy, u_if.rd_gnt, u_if.sram_A}, {1'b0, 1'b1, 9'd5});
        @(negedge CLK);
        u_if.rd_addr = 9'd20;
        #1;
        chk("post2_rd5", {u_if.rd_vld, u_if.rd_data}, {1'b1, C_Z});
        @(negedge CLK);
        u_if.rd_req = 1'b0;
        #1;
        chk("post2_rd20", {u_if.rd_vld, u_if.rd_data}, {1'b1, C_Z});

        // ---------------- reset in the middle of a sweep
        @(negedge CLK);
        u_if.init_req = 1'b1;
        @(negedge CLK);
        u_if.init_req = 1'b0;
        repeat (300) @(negedge CLK);
        #1;
        chk("abort_addr", {u_if.init_busy, u_if.sram_CEN, u_if.sram_GWEN, u_if.sram_A},
                          {1'b1, 1'b0, 1'b0, 9'd300});
        RST = 1'b1;
        u_if.rd_req = 1'b1;
        u_if.wr_req = 1'b1;
        #1;
        chk("abort_idle0", {u_if.rd_gnt, u_if.wr_gnt, u_if.rd_vld, u_if.init_busy, u_if.sram_CEN,
                            u_if.sram_GWEN, u_if.sram_A, u_if.sram_WEN, u_if.sram_D},
                           {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'd0, C_ONES, C_Z});
        @(negedge CLK);
        #1;
        chk("abort_idle1", {u_if.rd_gnt, u_if.wr_gnt, u_if.rd_vld, u_if.init_busy, u_if.sram_CEN,
                            u_if.sram_GWEN, u_if.sram_A, u_if.sram_WEN, u_if.sram_D},
                           {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'd0, C_ONES, C_Z});
        u_if.rd_req = 1'b0;
        u_if.wr_req = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("abort_restart", {u_if.init_busy, u_if.sram_CEN, u_if.sram_GWEN, u_if.sram_A},
                             {1'b1, 1'b0, 1'b0, 9'd0});
        busy_cnt = 1;
        for (int k = 0; k < 600; k++) begin
            @(negedge CLK);
            #1;
            if (!u_if.init_busy) break;
            busy_cnt++;
        end
        chk("abort_busy_len", 128'(busy_cnt), 128'(512));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
